// File: rtl/addsub_rr_arbiter.sv
// -----------------------------------------------------------------------------
// addsub_rr_arbiter
//
// Shares one registered WIDTH-bit add/subtract unit between four requesters.
// Each transaction takes three cycles: IDLE (arbitrate and latch operands),
// EXEC (compute and register the result), RESP (one-cycle DONE pulse). When
// requests are pending the FSM goes straight from RESP back through IDLE into
// the next grant, so there is no extra idle cycle between transactions.
// Arbitration is round-robin. After reset the pointer is 3, so requester 0
// has first priority.
//
// Ports
//   CLK       in   rising-edge clock
//   RESET     in   asynchronous, active-high reset; drops any in-flight op
//   REQ       in   [3:0]          per-requester request, held until its DONE
//   OP_A      in   [4*WIDTH-1:0]  packed operand A, slot i at [i*WIDTH +: WIDTH]
//   OP_B      in   [4*WIDTH-1:0]  packed operand B, same packing
//   OP_SUB    in   [3:0]          per-requester op: 0 = A+B, 1 = A-B
//   GNT       out  [3:0]          one-hot grant, zero when idle
//   GRANT_ID  out  [1:0]          index of the current/last winner
//   DONE      out  [3:0]          one-hot single-cycle completion pulse
//   RESULT    out  [WIDTH-1:0]    result of the last completed operation
//   FLAG      out                 carry (add) / borrow (sub) of last operation
//   BUSY      out                 high whenever the FSM is not IDLE
//   OPS_CNT   out  [CNT_W-1:0]    completed-operation count, wraps
// -----------------------------------------------------------------------------
module addsub_rr_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [3:0]         REQ,
  input  logic [4*WIDTH-1:0] OP_A,
  input  logic [4*WIDTH-1:0] OP_B,
  input  logic [3:0]         OP_SUB,
  output logic [3:0]         GNT,
  output logic [1:0]         GRANT_ID,
  output logic [3:0]         DONE,
  output logic [WIDTH-1:0]   RESULT,
  output logic               FLAG,
  output logic               BUSY,
  output logic [CNT_W-1:0]   OPS_CNT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q;
  logic [1:0]         ptr_q;
  logic [3:0]         gnt_q;
  logic [1:0]         grant_id_q;
  logic [3:0]         done_q;
  logic [WIDTH-1:0]   result_q;
  logic               flag_q;
  logic               busy_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               sub_q;

  logic [1:0]         winner_d;
  logic [WIDTH-1:0]   a_d;
  logic [WIDTH-1:0]   b_d;
  logic               sub_d;
  logic [WIDTH:0]     sum_ext_d;

  // Round-robin winner: the first set REQ bit in order ptr+1, ptr+2, ptr+3,
  // ptr. The loop walks from lowest to highest priority so that the last
  // match, i.e. the highest-priority one, is what remains.
  // NOTE: every variable assigned in always_comb gets a default first;
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    logic [1:0] cand;
    winner_d = '0;
    cand     = '0;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr_q + 2'(k);
      if (REQ[cand]) begin
        winner_d = cand;
      end
    end
  end

  // Operand mux: pick the winner's slot out of the packed operand buses.
  assign a_d   = OP_A[int'(winner_d)*WIDTH +: WIDTH];
  assign b_d   = OP_B[int'(winner_d)*WIDTH +: WIDTH];
  assign sub_d = OP_SUB[winner_d];

  // One extra bit holds the carry-out for an add. For a subtract of two
  // zero-extended values the same bit is set exactly when A < B, which is
  // the unsigned borrow.
  assign sum_ext_d = sub_q ? ({1'b0, a_q} - {1'b0, b_q})
                           : ({1'b0, a_q} + {1'b0, b_q});

  // NOTE: sequential state is assigned with <= only, so every register
  // samples the pre-edge values and the order of statements does not matter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      ptr_q      <= 2'd3;
      gnt_q      <= '0;
      grant_id_q <= '0;
      done_q     <= '0;
      result_q   <= '0;
      flag_q     <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|REQ) begin
            gnt_q      <= 4'b0001 << winner_d;
            grant_id_q <= winner_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sub_q      <= sub_d;
            busy_q     <= 1'b1;
            state_q    <= S_EXEC;
          end
        end
        S_EXEC: begin
          result_q <= sum_ext_d[WIDTH-1:0];
          flag_q   <= sum_ext_d[WIDTH];
          // Completion is steered to the requester that holds the grant.
          done_q   <= gnt_q;
          cnt_q    <= cnt_q + CNT_W'(1);
          state_q  <= S_RESP;
        end
        S_RESP: begin
          done_q  <= '0;
          gnt_q   <= '0;
          ptr_q   <= grant_id_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign GNT      = gnt_q;
  assign GRANT_ID = grant_id_q;
  assign DONE     = done_q;
  assign RESULT   = result_q;
  assign FLAG     = flag_q;
  assign BUSY     = busy_q;
  assign OPS_CNT  = cnt_q;

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_addsub_rr_arbiter
//
// Directed scenarios followed by randomized traffic. Every cycle is checked
// against a behavioural model that tracks which phase the shared unit is in
// and computes results with plain integer arithmetic. A second instance
// with CNT_W=2 shares the stimulus and is used to check counter wrap.
// -----------------------------------------------------------------------------
module tb_addsub_rr_arbiter;

  localparam int W = 4;

  logic           CLK = 1'b0;
  logic           RESET = 1'b1;
  logic [3:0]     req = '0;
  logic [4*W-1:0] op_a = '0;
  logic [4*W-1:0] op_b = '0;
  logic [3:0]     op_sub = '0;

  logic [3:0]     gnt, done;
  logic [1:0]     grant_id;
  logic [W-1:0]   result;
  logic           flag, busy;
  logic [7:0]     ops_cnt;

  logic [3:0]     gnt2, done2;
  logic [1:0]     grant_id2;
  logic [W-1:0]   result2;
  logic           flag2, busy2;
  logic [1:0]     ops_cnt2;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: phase 0 = idle, 1 = executing, 2 = responding.
  int m_phase, m_ptr, m_win, m_a, m_b, m_sub, m_res, m_flag, m_cnt;

  addsub_rr_arbiter #(.WIDTH(W), .CNT_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(req), .OP_A(op_a), .OP_B(op_b),
    .OP_SUB(op_sub), .GNT(gnt), .GRANT_ID(grant_id), .DONE(done),
    .RESULT(result), .FLAG(flag), .BUSY(busy), .OPS_CNT(ops_cnt)
  );

  addsub_rr_arbiter #(.WIDTH(W), .CNT_W(2)) dut_small (
    .CLK(CLK), .RESET(RESET), .REQ(req), .OP_A(op_a), .OP_B(op_b),
    .OP_SUB(op_sub), .GNT(gnt2), .GRANT_ID(grant_id2), .DONE(done2),
    .RESULT(result2), .FLAG(flag2), .BUSY(busy2), .OPS_CNT(ops_cnt2)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_ptr   = 3;
    m_win   = 0;
    m_a     = 0;
    m_b     = 0;
    m_sub   = 0;
    m_res   = 0;
    m_flag  = 0;
    m_cnt   = 0;
  endtask

  // Advance the model across one rising edge using the inputs as they are now.
  task automatic model_step();
    bit found;
    case (m_phase)
      0: begin
        if (req != 4'd0) begin
          found = 1'b0;
          for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_ptr + k) % 4;
            if (!found && req[c]) begin
              m_win = c;
              found = 1'b1;
            end
          end
          m_a     = int'((op_a >> (4 * m_win)) & 16'hF);
          m_b     = int'((op_b >> (4 * m_win)) & 16'hF);
          m_sub   = int'(op_sub[m_win]);
          m_phase = 1;
        end
      end
      1: begin
        if (m_sub != 0) begin
          m_res  = (m_a - m_b + 16) % 16;
          m_flag = (m_a < m_b) ? 1 : 0;
        end else begin
          m_res  = (m_a + m_b) % 16;
          m_flag = (m_a + m_b > 15) ? 1 : 0;
        end
        m_cnt   = m_cnt + 1;
        m_phase = 2;
      end
      default: begin
        m_ptr   = m_win;
        m_phase = 0;
      end
    endcase
  endtask

  task automatic check_outputs();
    logic [31:0] eg, ed;
    eg = (m_phase != 0) ? (32'd1 << m_win) : 32'd0;
    ed = (m_phase == 2) ? (32'd1 << m_win) : 32'd0;
    check("gnt",      gnt,      eg);
    check("done",     done,     ed);
    check("grant_id", grant_id, m_win);
    check("busy",     busy,     (m_phase != 0) ? 1 : 0);
    check("result",   result,   m_res);
    check("flag",     flag,     m_flag);
    check("ops_cnt",  ops_cnt,  m_cnt % 256);
    check("gnt_s",    gnt2,     eg);
    check("done_s",   done2,    ed);
    check("result_s", result2,  m_res);
    check("flag_s",   flag2,    m_flag);
    check("busy_s",   busy2,    (m_phase != 0) ? 1 : 0);
    check("gid_s",    grant_id2, m_win);
    check("ops_cnt_s", ops_cnt2, m_cnt % 4);
  endtask

  // One clock: model across the edge, then sample 1 ns after it.
  task automatic step();
    model_step();
    @(posedge CLK);
    #1;
    check_outputs();
  endtask

  // Assert RESET mid-cycle, confirm outputs clear at once and no grant is
  // issued while it is held, then release away from the clock edge.
  task automatic do_reset();
    #3;
    RESET = 1'b1;
    #1;
    model_reset();
    check_outputs();
    repeat (2) begin
      @(posedge CLK);
      #1;
      check_outputs();
    end
    RESET = 1'b0;
  endtask

  task automatic set_ops(input int i, input int a, input int b, input bit s);
    op_a[i*4 +: 4] = 4'(a);
    op_b[i*4 +: 4] = 4'(b);
    op_sub[i]      = s;
  endtask

  task automatic rand_ops(input int i);
    set_ops(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            bit'($urandom_range(0, 1)));
  endtask

  // Random requester behaviour, driven from the model's view of the cycle.
  task automatic auto_drive();
    for (int i = 0; i < 4; i++) begin
      if (m_phase == 2 && m_win == i) begin
        if ($urandom_range(0, 1) == 1) begin
          req[i] = 1'b1;
          rand_ops(i);
        end else begin
          req[i] = 1'b0;
        end
      end else if (!req[i]) begin
        if ($urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          rand_ops(i);
        end
      end else if (m_phase != 0 && m_win == i) begin
        // Operands and REQ may change once sampled; the result must not.
        if ($urandom_range(0, 7) == 0) rand_ops(i);
        if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
      end
    end
  endtask

  initial begin
    int order [5];
    int k;
    order = '{0, 1, 2, 3, 0};

    // Power-on reset state.
    model_reset();
    @(posedge CLK);
    #1;
    check_outputs();

    // Reset asserted mid-cycle with every requester active.
    req = 4'b1111;
    for (int i = 0; i < 4; i++) rand_ops(i);
    do_reset();

    // Full contention: every requester re-requests right after its DONE.
    k = 0;
    for (int s = 0; s < 15; s++) begin
      step();
      if (m_phase == 1 && k < 5) begin
        check("cont_order", gnt, 32'd1 << order[k]);
        k++;
      end
      if (m_phase == 2) rand_ops(m_win);
    end
    check("cont_cnt", ops_cnt, 5);
    req = 4'b0000;
    step();
    do_reset();

    // Single add on requester 0: 9 + 8 = 17 -> result 1, carry 1.
    set_ops(0, 9, 8, 1'b0);
    req = 4'b0001;
    step();
    check("add_gnt", gnt, 4'b0001);
    step();
    check("add_done", done, 4'b0001);
    check("add_res", result, 1);
    check("add_flag", flag, 1);
    check("add_cnt", ops_cnt, 1);
    req = 4'b0000;
    step();
    check("add_gnt_off", gnt, 0);

    // Subtract on requester 2: 3 - 5, then 5 - 3 as a re-request.
    set_ops(2, 3, 5, 1'b1);
    req = 4'b0100;
    step();
    step();
    check("sub1_done", done, 4'b0100);
    check("sub1_res", result, 4'hE);
    check("sub1_flag", flag, 1);
    set_ops(2, 5, 3, 1'b1);
    step();
    step();
    step();
    check("sub2_done", done, 4'b0100);
    check("sub2_res", result, 2);
    check("sub2_flag", flag, 0);
    req = 4'b0000;
    step();

    // Fairness: having just served 2, requester 3 beats requester 1.
    set_ops(1, 6, 7, 1'b0);
    set_ops(3, 10, 3, 1'b1);
    req = 4'b1010;
    step();
    check("fair_first", gnt, 4'b1000);
    step();
    req[3] = 1'b0;
    step();
    step();
    check("fair_second", gnt, 4'b0010);
    step();
    check("fair_res", result, 13);
    req = 4'b0000;
    step();

    // Abort: reset lands while requester 0 is in EXEC.
    set_ops(0, 7, 6, 1'b0);
    req = 4'b0001;
    step();
    req = 4'b0000;
    do_reset();
    check("abort_res", result, 0);
    check("abort_done", done, 0);
    repeat (3) step();

    // Counter wrap: five operations; the 2-bit counter reads 1.
    rand_ops(0);
    req = 4'b0001;
    for (int t = 0; t < 5; t++) begin
      step();
      step();
      rand_ops(0);
      if (t == 4) req = 4'b0000;
      step();
    end
    check("wrap_cnt_small", ops_cnt2, 1);
    check("wrap_cnt", ops_cnt, 5);

    // Randomized traffic with occasional resets.
    repeat (600) begin
      auto_drive();
      if ($urandom_range(0, 199) == 0) do_reset();
      else step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/addsub_rr_arbiter.md
Name: addsub_rr_arbiter

Overview:
- Shares one registered WIDTH-bit add/subtract unit among four requesters.
- Round-robin arbitration with a REQ/GNT/DONE handshake.
- Per-requester operands are selected through an internal operand mux. The completion pulse is steered to the winner through a one-hot demux.
- Sits between the basic-building-block datapath (adder/subtractor) and any number of up to four client engines.

Parameters:
- WIDTH, 4, operand and result width in bits (≥2).
- CNT_W, 8, width of the completed-operation counter.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- REQ  input  4  per-requester request; held high with stable operands until that requester's DONE pulse.
- OP_A  input  4*WIDTH  packed operand A; requester i at bits [i*WIDTH +: WIDTH].
- OP_B  input  4*WIDTH  packed operand B, same packing as OP_A.
- OP_SUB  input  4  per-requester operation: 0 = A+B, 1 = A−B.
- GNT  output  4  one-hot grant; all-zero when idle.
- GRANT_ID  output  2  encoded index of the current/last winner.
- DONE  output  4  one-hot, single-cycle completion pulse to the winner.
- RESULT  output  WIDTH  result of the last completed operation.
- FLAG  output  1  carry (add) or borrow (sub) of the last completed operation.
- BUSY  output  1  high whenever FSM is not IDLE.
- OPS_CNT  output  CNT_W  count of completed operations.

Behaviour:
- Reset (asynchronous, effective immediately, any state):
  - FSM → IDLE.
  - GNT=0, DONE=0, RESULT=0, FLAG=0, BUSY=0, GRANT_ID=0, OPS_CNT=0.
  - Round-robin pointer PTR=3, so requester 0 has first priority.
  - An in-flight transaction is dropped; no DONE is produced for it.
- FSM states: IDLE → EXEC → RESP → IDLE. Each transaction takes exactly 3 cycles; there is no idle gap when requests are pending.
- IDLE:
  - If REQ≠0, select the winner W as the first set REQ bit in search order PTR+1, PTR+2, PTR+3, PTR (mod 4).
  - On that edge: GNT=onehot(W), GRANT_ID=W, latch A_r/B_r/SUB_r from slot W, BUSY=1, go to EXEC.
  - If REQ=0, stay in IDLE; GNT stays 0.
- EXEC:
  - Compute {FLAG,RESULT} from the latched operands.
  - Add: (WIDTH+1)-bit sum of A_r+B_r; FLAG = carry-out.
  - Sub: RESULT = (A_r−B_r) mod 2^WIDTH; FLAG = 1 iff A_r<B_r (unsigned borrow).
  - On the edge: register RESULT/FLAG, set DONE=onehot(W), OPS_CNT+1 (wraps at 2^CNT_W), go to RESP.
- RESP:
  - DONE is high for this one cycle only; GNT is still asserted.
  - On the edge: DONE=0, GNT=0, PTR=W, BUSY=0, go to IDLE.
- Requester handshake: deassert REQ on the edge that samples DONE=1. REQ still high in the following IDLE cycle is treated as a new request.
- Operands are sampled only on the IDLE→EXEC edge. Later changes to OP_A/OP_B/OP_SUB, or REQ dropping mid-transaction, do not affect the result. DONE still pulses.
- Requests from other requesters during EXEC/RESP are not seen. They are arbitrated at the next IDLE.
- RESULT/FLAG hold their values between completions; they are not cleared in IDLE.
- GNT and DONE are never multi-hot. DONE is never high while BUSY=0.

Test Plan:
- Reset check: assert RESET mid-cycle with REQ=4'b1111 → all outputs 0 immediately, PTR=3, no GNT while RESET is high.
- Single add, WIDTH=4: REQ=0001, A0=9, B0=8, SUB=0.
  - GNT=0001 one edge after REQ is sampled.
  - DONE=0001 one cycle later with RESULT=1, FLAG=1, OPS_CNT=1.
  - GNT=0 the cycle after DONE.
- Subtract, requester 2:
  - 3−5 → RESULT=4'hE, FLAG=1.
  - Then 5−3 → RESULT=2, FLAG=0.
  - DONE=0100 for each.
- Full contention: REQ=1111 held, each requester re-requesting after its DONE → grant order 0,1,2,3,0, with a new GNT every 3 cycles; OPS_CNT increments by 1 per transaction.
- Fairness: after serving requester 2, assert REQ=1010 → requester 3 is granted before requester 1.
- Abort and wrap:
  - Assert RESET while in EXEC → no DONE for that transaction, RESULT=0.
  - Separately, with CNT_W=2, run 5 operations → OPS_CNT=1.
